// File: rtl/decode_cycle.sv
// RV32I decode stage: register file, control/ALU decode, immediate
// extension and the ID/EX pipeline register feeding execute.
//
// Ports:
//   clk, rst (async, active-low)
//   InstrD, PCD, PCPlus4D         fetch-side inputs (InstrD 0 = bubble)
//   RegWriteW, RDW, ResultW       writeback port into the register file
//   FlushE                        load a bubble into ID/EX on the next edge
//   Rs1D, Rs2D                    combinational source fields for hazards
//   *E                            registered ID/EX outputs
//
// Option macro REGFILE_BYPASS_EN: when defined, a same-cycle writeback to a
// register being read is forwarded through the read port (write-through).
module decode_cycle #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       InstrD,
    input  logic [31:0]       PCD,
    input  logic [31:0]       PCPlus4D,
    input  logic              RegWriteW,
    input  logic [4:0]        RDW,
    input  logic [DATA_W-1:0] ResultW,
    input  logic              FlushE,
    output logic [4:0]        Rs1D,
    output logic [4:0]        Rs2D,
    output logic              RegWriteE,
    output logic              MemWriteE,
    output logic              JumpE,
    output logic              BranchE,
    output logic              ALUSrcE,
    output logic [1:0]        ResultSrcE,
    output logic [2:0]        ALUControlE,
    output logic [DATA_W-1:0] RD1E,
    output logic [DATA_W-1:0] RD2E,
    output logic [DATA_W-1:0] ImmExtE,
    output logic [31:0]       PCE,
    output logic [31:0]       PCPlus4E,
    output logic [4:0]        RdE,
    output logic [4:0]        Rs1E,
    output logic [4:0]        Rs2E
);

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_J
    } imm_src_t;

    typedef struct packed {
        logic       reg_write;
        imm_src_t   imm_src;
        logic       alu_src;
        logic       mem_write;
        logic [1:0] result_src;
        logic       branch;
        logic [1:0] alu_op;
        logic       jump;
    } ctrl_t;

    typedef struct packed {
        logic              reg_write;
        logic              mem_write;
        logic              jump;
        logic              branch;
        logic              alu_src;
        logic [1:0]        result_src;
        logic [2:0]        alu_ctrl;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [31:0]       pc;
        logic [31:0]       pc_plus4;
        logic [4:0]        rd;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
    } id_ex_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    logic [6:0]        op;
    logic [2:0]        funct3;
    logic              funct7_5;
    logic [4:0]        rd;
    ctrl_t             ctrl;
    logic [2:0]        alu_ctrl;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              wb_en;
    logic              hit1;
    logic              hit2;
    logic [DATA_W-1:0] rf [NREGS];
    id_ex_t            d;
    id_ex_t            e;

    assign op       = InstrD[6:0];
    assign rd       = InstrD[11:7];
    assign funct3   = InstrD[14:12];
    assign Rs1D     = InstrD[19:15];
    assign Rs2D     = InstrD[24:20];
    assign funct7_5 = InstrD[30];

    always_comb begin
        ctrl = '0;
        case (op)
            7'b0000011: begin
                ctrl.reg_write  = 1'b1;
                ctrl.imm_src    = IMM_I;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = 2'b01;
            end
            7'b0100011: begin
                ctrl.imm_src   = IMM_S;
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            7'b0110011: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = 2'b10;
            end
            7'b1100011: begin
                ctrl.imm_src = IMM_B;
                ctrl.branch  = 1'b1;
                ctrl.alu_op  = 2'b01;
            end
            7'b0010011: begin
                ctrl.reg_write = 1'b1;
                ctrl.imm_src   = IMM_I;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = 2'b10;
            end
            7'b1101111: begin
                ctrl.reg_write  = 1'b1;
                ctrl.imm_src    = IMM_J;
                ctrl.result_src = 2'b10;
                ctrl.jump       = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    // Only R-type (op[5]=1) with funct7[5] set is a subtract; an I-type
    // immediate may have bit 30 set and must still add.
    always_comb begin
        alu_ctrl = ALU_ADD;
        unique case (1'b1)
            ctrl.alu_op == 2'b01: alu_ctrl = ALU_SUB;
            ctrl.alu_op == 2'b10: begin
                case (funct3)
                    3'b000:  alu_ctrl = (op[5] && funct7_5) ? ALU_SUB
                                                            : ALU_ADD;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b110:  alu_ctrl = ALU_OR;
                    3'b111:  alu_ctrl = ALU_AND;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

    always_comb begin
        imm = '0;
        case (ctrl.imm_src)
            IMM_I: imm = {{(DATA_W-12){InstrD[31]}}, InstrD[31:20]};
            IMM_S: imm = {{(DATA_W-12){InstrD[31]}}, InstrD[31:25],
                          InstrD[11:7]};
            IMM_B: imm = {{(DATA_W-12){InstrD[31]}}, InstrD[7],
                          InstrD[30:25], InstrD[11:8], 1'b0};
            IMM_J: imm = {{(DATA_W-20){InstrD[31]}}, InstrD[19:12],
                          InstrD[20], InstrD[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    assign wb_en = RegWriteW && (RDW != 5'd0);

`ifdef REGFILE_BYPASS_EN
    assign hit1 = wb_en && (RDW == Rs1D);
    assign hit2 = wb_en && (RDW == Rs2D);
`else
    assign hit1 = 1'b0;
    assign hit2 = 1'b0;
`endif

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (Rs1D != 5'd0) rd1 = hit1 ? ResultW : rf[Rs1D];
        if (Rs2D != 5'd0) rd2 = hit2 ? ResultW : rf[Rs2D];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (wb_en) begin
            rf[RDW] <= ResultW;
        end
    end

    always_comb begin
        d            = '0;
        d.reg_write  = ctrl.reg_write;
        d.mem_write  = ctrl.mem_write;
        d.jump       = ctrl.jump;
        d.branch     = ctrl.branch;
        d.alu_src    = ctrl.alu_src;
        d.result_src = ctrl.result_src;
        d.alu_ctrl   = alu_ctrl;
        d.rd1        = rd1;
        d.rd2        = rd2;
        d.imm        = imm;
        d.pc         = PCD;
        d.pc_plus4   = PCPlus4D;
        d.rd         = rd;
        d.rs1        = Rs1D;
        d.rs2        = Rs2D;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e <= '0;
        end else if (FlushE) begin
            e <= '0;
        end else begin
            e <= d;
        end
    end

    assign RegWriteE   = e.reg_write;
    assign MemWriteE   = e.mem_write;
    assign JumpE       = e.jump;
    assign BranchE     = e.branch;
    assign ALUSrcE     = e.alu_src;
    assign ResultSrcE  = e.result_src;
    assign ALUControlE = e.alu_ctrl;
    assign RD1E        = e.rd1;
    assign RD2E        = e.rd2;
    assign ImmExtE     = e.imm;
    assign PCE         = e.pc;
    assign PCPlus4E    = e.pc_plus4;
    assign RdE         = e.rd;
    assign Rs1E        = e.rs1;
    assign Rs2E        = e.rs2;

endmodule
